// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between the bridge (master side) and one memory completer (slave side).
interface apb_slave_mem_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_slave_mem.sv
// APB completer backed by a byte-wide register-array memory with parameterised wait states.
// Optional macro APB_SLV_ERR_EN: addresses >= MEM_DEPTH answer with PSLVERR instead of wrapping.
module apb_slave_mem #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic             PCLK,
    input  logic             RST,
    apb_slave_mem_if.slave   bus
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    localparam int                  IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [3:0]          WAIT_L  = 4'(WAIT_CYCLES);

    // One extra bit keeps MEM_DEPTH == 2**ADDR_WIDTH representable as a divisor.
    function automatic logic [IDX_W-1:0] mem_index(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] r;
        r = {1'b0, a} % DEPTH_L;
        return r[IDX_W-1:0];
    endfunction

    logic [0:0]            state_r;
    logic [3:0]            cnt_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  wr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

    logic                  setup_s;
    logic                  pready_s;
    logic                  oor_s;
    logic                  commit_s;
    logic [IDX_W-1:0]      idx_s;
    logic [DATA_WIDTH-1:0] prdata_s;

    // A setup phase (PSEL without PENABLE) restarts the transfer from either state.
    assign setup_s  = bus.PSEL && !bus.PENABLE;
    assign pready_s = (state_r == ST_ACCESS) && (cnt_r == 4'd0) && bus.PENABLE && bus.PSEL;
    assign idx_s    = mem_index(addr_r);
    assign commit_s = pready_s && wr_r && !oor_s;

    // Out-of-range detection for the captured address.
    always_comb begin
`ifdef APB_SLV_ERR_EN
        if ({1'b0, addr_r} >= DEPTH_L) begin
            oor_s = 1'b1;
        end else begin
            oor_s = 1'b0;
        end
`else
        oor_s = 1'b0;
`endif
    end

    // Read data is driven only in the completing cycle of an in-range read.
    always_comb begin
        if (pready_s && !wr_r && !oor_s) begin
            prdata_s = mem_r[idx_s];
        end else begin
            prdata_s = '0;
        end
    end

    assign bus.PREADY  = pready_s;
    assign bus.PRDATA  = prdata_s;
    assign bus.PSLVERR = pready_s && oor_s;

    // Transfer FSM and wait-state counter.
    always_ff @(posedge PCLK or negedge RST) begin
        if (!RST) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (setup_s) begin
                        state_r <= ST_ACCESS;
                        cnt_r   <= WAIT_L;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (!bus.PSEL) begin
                        state_r <= ST_IDLE;
                    end else if (setup_s) begin
                        state_r <= ST_ACCESS;
                        cnt_r   <= WAIT_L;
                    end else if (cnt_r != 4'd0) begin
                        cnt_r   <= cnt_r - 4'd1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

    // Capture of the transfer attributes in every setup phase; later bus changes are ignored.
    always_ff @(posedge PCLK or negedge RST) begin
        if (!RST) begin
            addr_r  <= '0;
            wr_r    <= 1'b0;
            wdata_r <= '0;
        end else if (setup_s) begin
            addr_r  <= bus.PADDR;
            wr_r    <= bus.PWRITE;
            wdata_r <= bus.PWDATA;
        end else begin
            addr_r  <= addr_r;
            wr_r    <= wr_r;
            wdata_r <= wdata_r;
        end
    end

    // Memory array: cleared by reset, written on the edge that ends a completing write.
    always_ff @(posedge PCLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (commit_s) begin
            mem_r[idx_s] <= wdata_r;
        end else begin
            mem_r[idx_s] <= mem_r[idx_s];
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench: three completers (0, 2 and 3 wait states) driven by one shared APB master.
module tb_apb_slave_mem;

`ifdef APB_SLV_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam int W0 = 0;
    localparam int W1 = 2;
    localparam int W2 = 3;
    localparam int WAITS [3] = '{W0, W1, W2};
    localparam int DEPTH = 64;

    logic       PCLK = 1'b0;
    logic       RST  = 1'b0;
    logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0] paddr = 8'h00, pwdata = 8'h00;

    always #5 PCLK = ~PCLK;

    apb_slave_mem_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus0 ();
    apb_slave_mem_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus1 ();
    apb_slave_mem_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus2 ();

    assign bus0.PSEL = psel;  assign bus0.PENABLE = penable; assign bus0.PWRITE = pwrite;
    assign bus0.PADDR = paddr; assign bus0.PWDATA = pwdata;
    assign bus1.PSEL = psel;  assign bus1.PENABLE = penable; assign bus1.PWRITE = pwrite;
    assign bus1.PADDR = paddr; assign bus1.PWDATA = pwdata;
    assign bus2.PSEL = psel;  assign bus2.PENABLE = penable; assign bus2.PWRITE = pwrite;
    assign bus2.PADDR = paddr; assign bus2.PWDATA = pwdata;

    apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(W0))
        dut0 (.PCLK(PCLK), .RST(RST), .bus(bus0));
    apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(W1))
        dut1 (.PCLK(PCLK), .RST(RST), .bus(bus1));
    apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(W2))
        dut2 (.PCLK(PCLK), .RST(RST), .bus(bus2));

    logic       rdy [3];
    logic       err [3];
    logic [7:0] rd  [3];
    assign rdy[0] = bus0.PREADY; assign err[0] = bus0.PSLVERR; assign rd[0] = bus0.PRDATA;
    assign rdy[1] = bus1.PREADY; assign err[1] = bus1.PSLVERR; assign rd[1] = bus1.PRDATA;
    assign rdy[2] = bus2.PREADY; assign err[2] = bus2.PSLVERR; assign rd[2] = bus2.PRDATA;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference memory contents per completer.
    logic [7:0] mdl [3][DEPTH];

    typedef struct {
        logic            wr;
        logic [7:0]      addr;
        logic [7:0]      data;
        int              max_acc;
        logic [2:0][7:0] exp_rd;
        logic            exp_err;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s dut%0d: got %0h expected %0h", name, k, act, exp);
    endtask

    function automatic bit completes(input int k, input int max_acc);
        return max_acc >= WAITS[k] + 1;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < DEPTH; i++) mdl[k][i] = 8'h00;
    endtask

    // One APB transfer holding the access phase for at most max_acc cycles; checks every
    // completer against the reference model. Called at a drive point (#1 after a rising edge).
    task automatic xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                        input int max_acc, output logic [2:0][7:0] got_rd,
                        output logic [2:0] got_err);
        int  cyc  [3];
        int  viol [3];
        int  acc;
        bit  all_done;
        bit  oor;
        int  idx;
        logic [7:0] exp_rd;
        for (int k = 0; k < 3; k++) begin
            cyc[k] = 0; viol[k] = 0;
        end
        got_rd  = '0;
        got_err = '0;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge PCLK); #1;
        penable = 1'b1; paddr = ~a; pwdata = ~d;
        acc = 0;
        while (1) begin
            acc++;
            @(negedge PCLK);
            all_done = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (cyc[k] == 0 && rdy[k]) begin
                    cyc[k]     = acc;
                    got_rd[k]  = rd[k];
                    got_err[k] = err[k];
                end else begin
                    if (rdy[k]) viol[k]++;
                    if (rd[k] != 8'h00 || err[k]) viol[k]++;
                end
                if (cyc[k] == 0) all_done = 1'b0;
            end
            @(posedge PCLK); #1;
            if (all_done || acc >= max_acc) break;
        end
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        oor = ERR_EN && (a >= 8'(DEPTH));
        idx = int'(a) % DEPTH;
        for (int k = 0; k < 3; k++) begin
            check("ready_cycle", k, cyc[k], completes(k, max_acc) ? WAITS[k] + 1 : 0);
            check("quiet_outputs", k, viol[k], 0);
            if (completes(k, max_acc)) begin
                exp_rd = (!wr && !oor) ? mdl[k][idx] : 8'h00;
                check("prdata", k, got_rd[k], exp_rd);
                check("pslverr", k, got_err[k], oor);
                if (wr && !oor) mdl[k][idx] = d;
            end
        end
        if (!completes(2, max_acc)) begin
            @(posedge PCLK); #1;
        end
    endtask

    initial begin
        logic [2:0][7:0] grd;
        logic [2:0]      gerr;
        logic            wr;
        logic [7:0]      a, d;
        int              macc;

        tbl[0]  = '{1'b1, 8'h10, 8'hA5, 8, {3{8'h00}}, 1'b0};
        tbl[1]  = '{1'b0, 8'h10, 8'h00, 8, {3{8'hA5}}, 1'b0};
        tbl[2]  = '{1'b1, 8'h05, 8'h3C, 8, {3{8'h00}}, 1'b0};
        tbl[3]  = '{1'b0, 8'h05, 8'h00, 8, {3{8'h3C}}, 1'b0};
        tbl[4]  = '{1'b1, 8'h20, 8'hFF, 1, {3{8'h00}}, 1'b0};
        tbl[5]  = '{1'b0, 8'h20, 8'h00, 8, {8'h00, 8'h00, 8'hFF}, 1'b0};
        tbl[6]  = '{1'b1, 8'h50, 8'h77, 8, {3{8'h00}}, ERR_EN};
        tbl[7]  = '{1'b0, 8'h10, 8'h00, 8, {3{ERR_EN ? 8'hA5 : 8'h77}}, 1'b0};
        tbl[8]  = '{1'b0, 8'h50, 8'h00, 8, {3{ERR_EN ? 8'h00 : 8'h77}}, ERR_EN};
        tbl[9]  = '{1'b1, 8'h3F, 8'h11, 8, {3{8'h00}}, 1'b0};
        tbl[10] = '{1'b0, 8'h3F, 8'h00, 8, {3{8'h11}}, 1'b0};
        tbl[11] = '{1'b1, 8'h7F, 8'h22, 8, {3{8'h00}}, ERR_EN};
        tbl[12] = '{1'b0, 8'h3F, 8'h00, 8, {3{ERR_EN ? 8'h11 : 8'h22}}, 1'b0};
        tbl[13] = '{1'b0, 8'h7F, 8'h00, 8, {3{ERR_EN ? 8'h00 : 8'h22}}, ERR_EN};

        // Reset held for three cycles.
        repeat (3) @(negedge PCLK);
        for (int k = 0; k < 3; k++) begin
            check("reset_pready", k, rdy[k], 1'b0);
            check("reset_pslverr", k, err[k], 1'b0);
            check("reset_prdata", k, rd[k], 8'h00);
        end
        @(posedge PCLK); #1;
        RST = 1'b1;
        model_clear();
        @(posedge PCLK); #1;

        for (int i = 0; i < DEPTH; i++) xfer(1'b0, 8'(i), 8'h00, 8, grd, gerr);

        // Directed table.
        for (int t = 0; t < 14; t++) begin
            xfer(tbl[t].wr, tbl[t].addr, tbl[t].data, tbl[t].max_acc, grd, gerr);
            for (int k = 0; k < 3; k++) begin
                if (completes(k, tbl[t].max_acc)) begin
                    check($sformatf("tbl%0d_prdata", t), k, grd[k], tbl[t].exp_rd[k]);
                    check($sformatf("tbl%0d_pslverr", t), k, gerr[k], tbl[t].exp_err);
                end
            end
        end

        // Reset during the wait states of a write.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h33; pwdata = 8'h5A;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(negedge PCLK);
        @(posedge PCLK); #1;
        @(negedge PCLK);
        check("pre_reset_wait", 2, rdy[2], 1'b0);
        RST = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("midrst_pready", k, rdy[k], 1'b0);
            check("midrst_pslverr", k, err[k], 1'b0);
            check("midrst_prdata", k, rd[k], 8'h00);
        end
        @(posedge PCLK); #1;
        @(posedge PCLK); #1;
        RST = 1'b1;
        model_clear();
        // PENABLE still high with PSEL: completers must sit in IDLE and ignore it.
        repeat (2) begin
            @(negedge PCLK);
            for (int k = 0; k < 3; k++) check("post_rst_idle", k, rdy[k], 1'b0);
            @(posedge PCLK); #1;
        end
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge PCLK); #1;
        xfer(1'b0, 8'h33, 8'h00, 8, grd, gerr);
        for (int k = 0; k < 3; k++) check("midrst_target", k, grd[k], 8'h00);
        xfer(1'b0, 8'h10, 8'h00, 8, grd, gerr);

        // Randomised traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            wr   = 1'($urandom_range(0, 1));
            a    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                               : 8'($urandom_range(0, 15));
            d    = 8'($urandom_range(0, 255));
            macc = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 8;
            xfer(wr, a, d, macc, grd, gerr);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB completer (slave) at the far end of the APB bridge; one instance per slave in the two-slave system.
- The bridge drives PSEL, PENABLE, PWRITE, PADDR and PWDATA. This block answers with PRDATA, PREADY and PSLVERR.
- Backing store is a byte-wide register-array memory.
- Number of wait states per transfer is set by a parameter, so bench reads and writes see realistic APB timing.

Parameters:
- ADDR_WIDTH, 8, width of PADDR.
- DATA_WIDTH, 8, width of PWDATA/PRDATA.
- MEM_DEPTH, 64, number of memory locations (must be ≤ 2**ADDR_WIDTH).
- WAIT_CYCLES, 0, PREADY-low cycles inserted in each ACCESS phase (0..15).

Ports:
- PCLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-low reset.
- PSEL  input  1  slave select from the bridge.
- PENABLE  input  1  access-phase strobe.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  ADDR_WIDTH  transfer address.
- PWDATA  input  DATA_WIDTH  write data.
- PRDATA  output  DATA_WIDTH  read data, valid only while PREADY=1 on a read.
- PREADY  output  1  transfer-complete indication.
- PSLVERR  output  1  error response, valid only while PREADY=1.

Behaviour:
- Reset (RST=0, asynchronous):
  - state=IDLE, wait counter=0.
  - All memory locations=0.
  - PRDATA=0, PREADY=0, PSLVERR=0.
  - Reset asserted mid-transfer aborts the transfer; no write is committed.
- FSM states: IDLE, ACCESS.
  - IDLE, PSEL=1 and PENABLE=0 (setup phase):
    - Capture PADDR, PWRITE, PWDATA into addr_q/wr_q/wdata_q.
    - Load counter with WAIT_CYCLES.
    - Go to ACCESS.
  - IDLE, PSEL=1 and PENABLE=1: protocol violation. Ignore and stay in IDLE.
  - ACCESS, PSEL=1 and PENABLE=1:
    - counter≠0: PREADY=0; decrement counter.
    - counter=0: PREADY=1. On the next edge, commit the write (if wr_q) and return to IDLE.
  - ACCESS, PSEL=0: abort. No write, PREADY stays 0, return to IDLE.
  - ACCESS, PSEL=1 and PENABLE=0: abort and treat as a new setup phase (recapture, reload counter, stay in ACCESS).
- Latency:
  - WAIT_CYCLES=0 → PREADY=1 in the first access cycle (2-cycle transfer).
  - In general, a transfer takes 2+WAIT_CYCLES cycles from setup to completion.
- PREADY is combinational from registered state only: (state==ACCESS && counter==0 && PENABLE && PSEL). There is no path from PADDR/PWDATA to PREADY.
- Reads:
  - PRDATA=mem[addr_q index] while PREADY=1 and wr_q=0.
  - Otherwise PRDATA=0.
- Writes: mem[index] ← wdata_q on the rising edge that ends the PREADY=1 cycle.
- Address index = addr_q modulo MEM_DEPTH. A non-power-of-two MEM_DEPTH uses the same modulo rule.
- Back-to-back transfers: a setup phase in the cycle immediately after completion is accepted from IDLE with no bubble beyond APB's inherent setup cycle.
- Read-after-write to the same address in the next transfer returns the new data.
- PWDATA/PADDR changes during ACCESS are ignored; captured values are used.

Optional Feature:
- Macro: APB_SLV_ERR_EN.
- Defined:
  - A transfer with addr_q ≥ MEM_DEPTH completes normally with PREADY=1, including wait states, and PSLVERR=1.
  - No write is committed, and PRDATA=0.
  - PSLVERR is asserted only in the PREADY=1 cycle.
- Undefined:
  - PSLVERR is tied to 0.
  - Out-of-range addresses wrap modulo MEM_DEPTH and complete normally.

Test Plan:
- Reset:
  - Stimulus: hold RST=0 for 3 cycles, release.
  - Response: PREADY=0, PSLVERR=0, PRDATA=0; reads of addresses 0x00..0x3F all return 0x00.
- Write then read, WAIT_CYCLES=0:
  - Stimulus: write 0xA5 to 0x10, then read 0x10.
  - Response: each transfer sees PREADY=1 on its 2nd cycle; the read returns PRDATA=0xA5.
- Wait states, WAIT_CYCLES=3:
  - Stimulus: write 0x3C to 0x05.
  - Response: PREADY=0 for 3 access cycles, then PREADY=1 in the 4th access cycle.
  - Follow-up: a read of 0x05 returns 0x3C after the same number of wait states.
- Abort:
  - Stimulus: start a write of 0xFF to 0x20 (WAIT_CYCLES=2), drop PSEL after 1 access cycle.
  - Response: no PREADY pulse; a later read of 0x20 returns the old value, 0x00.
- Out-of-range address:
  - With APB_SLV_ERR_EN, write 0x77 to 0x50: PREADY=1 with PSLVERR=1; a read of 0x10 (=0x50 mod 64) is unchanged.
  - Without the macro, the same write gives PSLVERR=0, and a read of 0x10 returns 0x77.
- Mid-transfer reset:
  - Stimulus: assert RST during the ACCESS wait of a write.
  - Response: outputs go to 0 immediately, FSM returns to IDLE, and the target location reads 0x00 after reset.
